// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and the NOP word.
// The hazard unit imports the same package so both sides agree on state meaning.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one I-mem request in flight and
// feeds the IF/ID register, honouring stalls and redirects from later stages.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemValid,
    input  logic [31:0] IMemData,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PCPlus4,
    output logic        IF_Valid,
    output logic [31:0] PC
);

    // state | meaning
    // REQ   | issue a request for pc this cycle
    // WAIT  | live request outstanding; a response is delivered or buffered
    // HOLD  | response parked in hold_buf until decode accepts it
    // DRAIN | killed request outstanding; its response is thrown away

    fetch_state_e state, state_nxt;

    logic [31:0] pc, pc_nxt, pc_plus4;
    logic [31:0] hold_buf;
    logic [31:0] instr_q, pcp4_q;
    logic        valid_q;

    logic        req;
    logic        deliver_mem;
    logic        deliver_buf;
    logic        capture;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        state_nxt   = state;
        req         = 1'b0;
        deliver_mem = 1'b0;
        deliver_buf = 1'b0;
        capture     = 1'b0;

        case (state)
            REQ: begin
                req       = 1'b1;
                // the request leaves even on redirect, so its reply must be drained
                state_nxt = Redirect ? DRAIN : WAIT;
            end
            WAIT: begin
                if (IMemValid) begin
                    if (Redirect) begin
                        state_nxt = REQ;
                    end else if (Stall) begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        deliver_mem = 1'b1;
                        req         = 1'b1;
                    end
                end else if (Redirect) begin
                    state_nxt = DRAIN;
                end
            end
            HOLD: begin
                if (Redirect) begin
                    state_nxt = REQ;
                end else if (!Stall) begin
                    deliver_buf = 1'b1;
                    state_nxt   = REQ;
                end
            end
            DRAIN: begin
                // a response landing together with another redirect still retires the kill
                if (IMemValid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase
    end

    always_comb begin
        pc_nxt = pc;
        if (Redirect) begin
            pc_nxt = word_align(RedirectPC);
        end else if (deliver_mem || deliver_buf) begin
            pc_nxt = pc_plus4;
        end
    end

    // back-to-back delivery requests the following word without a REQ bubble
    assign IMemReq  = req && Reset;
    assign IMemAddr = deliver_mem ? pc_plus4 : pc;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= REQ;
            pc       <= RESET_PC;
            hold_buf <= NOP_INSTR;
            instr_q  <= NOP_INSTR;
            pcp4_q   <= 32'h0000_0000;
            valid_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (capture) begin
                hold_buf <= IMemData;
            end
            if (Redirect) begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end else if (deliver_mem) begin
                instr_q <= IMemData;
                pcp4_q  <= pc_plus4;
                valid_q <= 1'b1;
            end else if (deliver_buf) begin
                instr_q <= hold_buf;
                pcp4_q  <= pc_plus4;
                valid_q <= 1'b1;
            end else if (!Stall) begin
                instr_q <= NOP_INSTR;
                valid_q <= 1'b0;
            end
        end
    end

    assign IF_Instruction = instr_q;
    assign IF_PCPlus4     = pcp4_q;
    assign IF_Valid       = valid_q;
    assign PC             = pc;

endmodule
